// File: rtl/td4_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : td4_ctrl_pkg
// Brief    : Shared state/command encodings and sizing for the TD4 run controller.
// Revision : 1.0
// ============================================================================
package td4_ctrl_pkg;

  localparam int c_DEF_PROG_DEPTH = 16;
  localparam int c_DEF_ADDR_W     = $clog2(c_DEF_PROG_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_HALT = 2'd3
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/td4_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : td4_run_ctrl_if
// Brief    : Command, program-byte stream and CPU control bundle of the run controller.
// Revision : 1.0
// ============================================================================
interface td4_run_ctrl_if
  import td4_ctrl_pkg::*;
#(
  parameter int PROG_DEPTH = c_DEF_PROG_DEPTH,
  parameter int DIV_W      = 8
);
  localparam int c_AW = $clog2(PROG_DEPTH);

  logic             cmd_valid;
  logic [1:0]       cmd;
  logic [DIV_W-1:0] div;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic             mem_we;
  logic [c_AW-1:0]  mem_addr;
  logic [7:0]       mem_wdata;
  logic             cpu_ce;
  logic             cpu_rst_n;
  logic             loaded;
  logic [1:0]       state;

  modport master (
    output cmd_valid, cmd, div, data_in, data_valid,
    input  data_ready, mem_we, mem_addr, mem_wdata, cpu_ce, cpu_rst_n, loaded, state
  );

  modport slave (
    input  cmd_valid, cmd, div, data_in, data_valid,
    output data_ready, mem_we, mem_addr, mem_wdata, cpu_ce, cpu_rst_n, loaded, state
  );
endinterface
`default_nettype wire

// File: rtl/td4_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : td4_prescaler
// Brief    : Divide-by-(div+1) strobe generator; divisor latched on clr.
// Revision : 1.0
// ============================================================================
module td4_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_count;
  logic             r_strobe;
  logic             w_wrap;

  assign w_wrap = (r_count == r_div_q);

  // Count only advances on enabled cycles, so a paused run resumes in phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q  <= '0;
      r_count  <= '0;
      r_strobe <= 1'b0;
    end else if (clr) begin
      r_div_q  <= div;
      r_count  <= '0;
      r_strobe <= 1'b0;
    end else if (en) begin
      r_strobe <= w_wrap;
      r_count  <= w_wrap ? '0 : r_count + 1'b1;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign strobe = r_strobe;
endmodule
`default_nettype wire

// File: rtl/td4_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : td4_run_ctrl
// Brief    : Loads the TD4 program over a byte stream, then runs or single-steps the CPU.
// Revision : 1.0
// ============================================================================
module td4_run_ctrl
  import td4_ctrl_pkg::*;
#(
  parameter int PROG_DEPTH = c_DEF_PROG_DEPTH,
  parameter int DIV_W      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  td4_run_ctrl_if.slave bus
);
  localparam int                  c_ADDR_W    = $clog2(PROG_DEPTH);
  localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(PROG_DEPTH - 1);

  state_t              r_state, w_state_nx;
  cmd_t                w_cmd;
  logic                r_loaded, w_loaded_nx;
  logic [c_ADDR_W-1:0] r_cnt, w_cnt_nx;
  logic                r_cpu_rst_n, w_cpu_rst_n_nx;
  logic                r_mem_we, w_mem_we_nx;
  logic [c_ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
  logic [7:0]          r_mem_wdata, w_mem_wdata_nx;
  logic                r_step_ce, w_step_ce_nx;
  logic                r_data_ready, w_data_ready_nx;
  logic                w_presc_clr, w_presc_en, w_presc_strobe;

  assign w_cmd      = cmd_t'(bus.cmd);
  assign w_presc_en = ena && (r_state == RUN);

  always_comb begin
    w_state_nx     = r_state;
    w_loaded_nx    = r_loaded;
    w_cnt_nx       = r_cnt;
    w_cpu_rst_n_nx = r_cpu_rst_n;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_step_ce_nx   = 1'b0;
    w_presc_clr    = 1'b0;
    // ena is sampled like any input: low freezes state and zeroes the strobes at the next edge.
    if (ena) begin
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          case (w_cmd)
            CMD_LOAD: begin
              w_state_nx     = LOAD;
              w_loaded_nx    = 1'b0;
              w_cpu_rst_n_nx = 1'b0;
              w_cnt_nx       = '0;
            end
            CMD_RUN: if (r_loaded) begin
              w_state_nx     = RUN;
              w_presc_clr    = 1'b1;
              w_cpu_rst_n_nx = 1'b1;
            end
            CMD_STEP: if (r_loaded) begin
              w_state_nx     = STEP;
              w_cpu_rst_n_nx = 1'b1;
            end
            default: ;
          endcase
        end
        LOAD: begin
          // HALT takes priority over a byte offered in the same cycle.
          if (bus.cmd_valid && (w_cmd == CMD_HALT)) begin
            w_state_nx = IDLE;
          end else if (bus.data_valid && r_data_ready) begin
            w_mem_we_nx    = 1'b1;
            w_mem_addr_nx  = r_cnt;
            w_mem_wdata_nx = bus.data_in;
            w_cnt_nx       = r_cnt + 1'b1;
            if (r_cnt == c_LAST_ADDR) begin
              w_loaded_nx = 1'b1;
              w_state_nx  = IDLE;
            end
          end
        end
        RUN: if (bus.cmd_valid) begin
          if (w_cmd == CMD_HALT) begin
            w_state_nx = IDLE;
          end else if (w_cmd == CMD_LOAD) begin
            w_state_nx     = LOAD;
            w_loaded_nx    = 1'b0;
            w_cpu_rst_n_nx = 1'b0;
            w_cnt_nx       = '0;
          end
        end
        STEP: begin
          w_step_ce_nx = 1'b1;
          w_state_nx   = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
    w_data_ready_nx = ena && (w_state_nx == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_loaded     <= 1'b0;
      r_cnt        <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_step_ce    <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_loaded     <= w_loaded_nx;
      r_cnt        <= w_cnt_nx;
      r_cpu_rst_n  <= w_cpu_rst_n_nx;
      r_mem_we     <= w_mem_we_nx;
      r_mem_addr   <= w_mem_addr_nx;
      r_mem_wdata  <= w_mem_wdata_nx;
      r_step_ce    <= w_step_ce_nx;
      r_data_ready <= w_data_ready_nx;
    end
  end

  td4_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_presc_en),
    .clr    (w_presc_clr),
    .div    (bus.div),
    .strobe (w_presc_strobe)
  );

  // Step and run strobes are mutually exclusive by construction.
  assign bus.cpu_ce     = r_step_ce | w_presc_strobe;
  assign bus.data_ready = r_data_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_rst_n  = r_cpu_rst_n;
  assign bus.loaded     = r_loaded;
  assign bus.state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_td4_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_run_ctrl
// Brief    : Scenario bench for td4_run_ctrl with an edge-indexed reference model.
// Revision : 1.0
// ============================================================================
module tb_td4_run_ctrl;
  import td4_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rst_hi_cnt = 0;

  logic [11:0] wr_q[$];
  int          ce_q[$];
  int          exp_q[$];
  logic [7:0]  prog[16];

  td4_run_ctrl_if #(.PROG_DEPTH(16), .DIV_W(8)) bus ();

  td4_run_ctrl #(.PROG_DEPTH(16), .DIV_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.cpu_ce === 1'b1) ce_q.push_back(cyc);
    if (bus.cpu_rst_n === 1'b1) rst_hi_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cmd_pulse(input logic [1:0] c, output int n);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_bytes(input int first, input int cnt, input bit gaps);
    int   idx = first;
    int   guard = 0;
    logic rdy, v;
    while (idx < first + cnt && guard < 400) begin
      rdy = bus.data_ready;
      v   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.data_valid = v;
      bus.data_in    = prog[idx];
      @(negedge clk);
      if (v && rdy) idx++;
      guard++;
    end
    bus.data_valid = 1'b0;
    total++; if (idx != first + cnt) begin bad++; $display("FAIL send_bytes accepted=%0d required=%0d", idx - first, cnt); end
  endtask

  task automatic check_writes(input int n_exp);
    logic [3:0]  a;
    logic [11:0] e;
    total++; if (wr_q.size() != n_exp) begin bad++; $display("FAIL write_count got=%0d exp=%0d", wr_q.size(), n_exp); end
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      a = 4'(i);
      e = {a, prog[i]};
      total++; if (wr_q[i] !== e) begin bad++; $display("FAIL write[%0d] got=%03h exp=%03h", i, wr_q[i], e); end
    end
  endtask

  task automatic check_ce();
    total++; if (ce_q.size() != exp_q.size()) begin bad++; $display("FAIL ce_count got=%0d exp=%0d", ce_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ce_q.size(); i++) begin
      total++; if (ce_q[i] != exp_q[i]) begin bad++; $display("FAIL ce_cycle[%0d] got=%0d exp=%0d", i, ce_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.state !== 2'd0)      begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    total++; if (bus.loaded !== 1'b0)     begin bad++; $display("FAIL reset_loaded got=%b exp=0", bus.loaded); end
    total++; if (bus.mem_we !== 1'b0)     begin bad++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.cpu_ce !== 1'b0)     begin bad++; $display("FAIL reset_cpu_ce got=%b exp=0", bus.cpu_ce); end
    total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready got=%b exp=0", bus.data_ready); end
    total++; if (bus.cpu_rst_n !== 1'b0)  begin bad++; $display("FAIL reset_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
    total++; if (bus.mem_addr !== 4'd0)   begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'd0)  begin bad++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.state !== 2'd0)      begin bad++; $display("FAIL post_reset_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_load_seq();
    int n, t0, r0;
    for (int i = 0; i < 16; i++) prog[i] = 8'(i);
    wr_q.delete();
    r0 = rst_hi_cnt;
    cmd_pulse(CMD_LOAD, n);
    total++; if (bus.state !== 2'd1)      begin bad++; $display("FAIL load_entry_state got=%0d exp=1", bus.state); end
    total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b exp=1", bus.data_ready); end
    t0 = cyc;
    send_bytes(0, 16, 1'b0);
    total++; if (cyc - t0 != 16)          begin bad++; $display("FAIL load_cycles got=%0d exp=16", cyc - t0); end
    total++; if (bus.loaded !== 1'b1)     begin bad++; $display("FAIL load_loaded got=%b exp=1", bus.loaded); end
    total++; if (bus.state !== 2'd0)      begin bad++; $display("FAIL load_done_state got=%0d exp=0", bus.state); end
    @(negedge clk);
    check_writes(16);
    total++; if (rst_hi_cnt != r0)        begin bad++; $display("FAIL load_cpu_rst_n high_cycles got=%0d exp=0", rst_hi_cnt - r0); end
  endtask

  task automatic run_case(input int d, input int periods, input int extra);
    int n, h;
    ce_q.delete();
    exp_q.delete();
    bus.div = 8'(d);
    cmd_pulse(CMD_RUN, n);
    total++; if (bus.state !== 2'd2)     begin bad++; $display("FAIL run_state div=%0d got=%0d exp=2", d, bus.state); end
    total++; if (bus.cpu_rst_n !== 1'b1) begin bad++; $display("FAIL run_cpu_rst_n div=%0d got=%b exp=1", d, bus.cpu_rst_n); end
    wait_until(n + periods * (d + 1) + extra - 1);
    cmd_pulse(CMD_HALT, h);
    wait_until(h + d + 3);
    for (int k = 1; n + k * (d + 1) <= h; k++) exp_q.push_back(n + k * (d + 1));
    check_ce();
    total++; if (bus.state !== 2'd0)     begin bad++; $display("FAIL halt_state div=%0d got=%0d exp=0", d, bus.state); end
    total++; if (bus.cpu_rst_n !== 1'b1) begin bad++; $display("FAIL halt_cpu_rst_n div=%0d got=%b exp=1", d, bus.cpu_rst_n); end
  endtask

  task automatic test_run();
    run_case(3, 3, 1);
    run_case(int'($urandom_range(1, 6)), int'($urandom_range(2, 4)), 0);
    run_case(255, 2, 5);
  endtask

  task automatic test_step();
    int n, dummy;
    for (int s = 0; s < 3; s++) begin
      ce_q.delete();
      cmd_pulse(CMD_STEP, n);
      total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL step_state[%0d] got=%0d exp=3", s, bus.state); end
      if (s == 1) cmd_pulse(CMD_RUN, dummy);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      wait_until(n + 4);
      total++; if (ce_q.size() != 1) begin bad++; $display("FAIL step_ce_count[%0d] got=%0d exp=1", s, ce_q.size()); end
      if (ce_q.size() > 0) begin
        total++; if (ce_q[0] != n + 1) begin bad++; $display("FAIL step_ce_cycle[%0d] got=%0d exp=%0d", s, ce_q[0], n + 1); end
      end
      total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL step_end_state[%0d] got=%0d exp=0", s, bus.state); end
    end
    total++; if (bus.cpu_rst_n !== 1'b1) begin bad++; $display("FAIL step_cpu_rst_n got=%b exp=1", bus.cpu_rst_n); end
  endtask

  task automatic test_unloaded();
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ce_q.delete();
    bus.div = 8'd0;
    cmd_pulse(CMD_RUN, n);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL unloaded_run_state got=%0d exp=0", bus.state); end
    cmd_pulse(CMD_STEP, n);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL unloaded_step_state got=%0d exp=0", bus.state); end
    repeat (8) @(negedge clk);
    total++; if (ce_q.size() != 0)   begin bad++; $display("FAIL unloaded_ce_count got=%0d exp=0", ce_q.size()); end
    total++; if (bus.cpu_rst_n !== 1'b0) begin bad++; $display("FAIL unloaded_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
  endtask

  task automatic test_abort();
    int n;
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    wr_q.delete();
    cmd_pulse(CMD_LOAD, n);
    send_bytes(0, 5, 1'b0);
    bus.data_valid = 1'b1;
    bus.data_in    = prog[5];
    bus.cmd_valid  = 1'b1;
    bus.cmd        = CMD_HALT;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.cmd_valid  = 1'b0;
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", bus.state); end
    @(negedge clk);
    check_writes(5);
    total++; if (bus.loaded !== 1'b0)    begin bad++; $display("FAIL abort_loaded got=%b exp=0", bus.loaded); end
    total++; if (bus.cpu_rst_n !== 1'b0) begin bad++; $display("FAIL abort_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
    ce_q.delete();
    cmd_pulse(CMD_RUN, n);
    repeat (5) @(negedge clk);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL abort_run_state got=%0d exp=0", bus.state); end
    total++; if (ce_q.size() != 0)   begin bad++; $display("FAIL abort_run_ce got=%0d exp=0", ce_q.size()); end
  endtask

  task automatic test_ena();
    int n, a, h, m, d;
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    wr_q.delete();
    cmd_pulse(CMD_LOAD, n);
    send_bytes(0, 16, 1'b1);
    @(negedge clk);
    check_writes(16);
    total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL ena_load_loaded got=%b exp=1", bus.loaded); end
    for (int it = 0; it < 2; it++) begin
      d = (it == 0) ? 0 : int'($urandom_range(1, 4));
      ce_q.delete();
      exp_q.delete();
      bus.div = 8'(d);
      cmd_pulse(CMD_RUN, n);
      wait_until(n + 5);
      a = cyc;
      ena = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.state !== 2'd2)      begin bad++; $display("FAIL ena_low_state div=%0d got=%0d exp=2", d, bus.state); end
      total++; if (bus.cpu_ce !== 1'b0)     begin bad++; $display("FAIL ena_low_cpu_ce div=%0d got=%b exp=0", d, bus.cpu_ce); end
      repeat (2) @(negedge clk);
      ena = 1'b1;
      wait_until(a + 11);
      cmd_pulse(CMD_HALT, h);
      wait_until(h + 3);
      // A pulse falls on every (d+1)-th edge at which ena was high.
      m = 0;
      for (int k = n + 1; k <= h; k++) begin
        if (k >= a + 1 && k <= a + 4) continue;
        m++;
        if (m % (d + 1) == 0) exp_q.push_back(k);
      end
      check_ce();
    end
  endtask

  task automatic test_rst_mid();
    int n;
    bus.div = 8'd0;
    cmd_pulse(CMD_RUN, n);
    repeat (3) @(negedge clk);
    total++; if (bus.cpu_ce !== 1'b1) begin bad++; $display("FAIL midrun_cpu_ce got=%b exp=1", bus.cpu_ce); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.state, bus.loaded, bus.mem_we, bus.cpu_ce, bus.data_ready, bus.cpu_rst_n, bus.mem_addr, bus.mem_wdata} !== 19'd0)
      begin bad++; $display("FAIL midrun_reset_outputs st=%0d ld=%b we=%b ce=%b rdy=%b crst=%b exp all 0", bus.state, bus.loaded, bus.mem_we, bus.cpu_ce, bus.data_ready, bus.cpu_rst_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    wr_q.delete();
    cmd_pulse(CMD_LOAD, n);
    send_bytes(0, 7, 1'b0);
    bus.data_valid = 1'b1;
    bus.data_in    = prog[7];
    @(negedge clk);
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL midload_mem_we got=%b exp=1", bus.mem_we); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.state, bus.loaded, bus.mem_we, bus.cpu_ce, bus.data_ready, bus.cpu_rst_n, bus.mem_addr, bus.mem_wdata} !== 19'd0)
      begin bad++; $display("FAIL midload_reset_outputs st=%0d we=%b addr=%0d data=%0h exp all 0", bus.state, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (wr_q.size() != 8) begin bad++; $display("FAIL midload_writes got=%0d exp=8", wr_q.size()); end
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    wr_q.delete();
    cmd_pulse(CMD_LOAD, n);
    send_bytes(0, 16, 1'b0);
    @(negedge clk);
    check_writes(16);
    total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL reload_loaded got=%b exp=1", bus.loaded); end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd        = 2'd0;
    bus.div        = 8'd0;
    bus.data_in    = 8'd0;
    bus.data_valid = 1'b0;
    test_reset();
    test_load_seq();
    test_run();
    test_step();
    test_unloaded();
    test_abort();
    test_ena();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/td4_run_ctrl.md
# td4_run_ctrl

Sequencer sitting between the TinyTapeout pin interface and the TD4 CPU core inside `tt_um_cpu_test`. It loads a 16-byte program into program memory over a valid/ready byte stream. It holds the CPU in reset until a program is present. It then runs the CPU free-running at a programmable rate, or single-steps it, by generating a one-cycle clock-enable strobe.

## Interface
- `PROG_DEPTH`, 16: program words; address width is clog2(PROG_DEPTH) = 4.
- `DIV_W`, 8: prescaler divisor width.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: TT enable; low freezes all state and counters.
- `cmd_valid` in 1: one-cycle command strobe.
- `cmd` in 2: command code; 0 = LOAD, 1 = RUN, 2 = STEP, 3 = HALT.
- `div` in DIV_W: RUN rate; the strobe period is div+1 cycles; latched on RUN entry.
- `data_in` in 8: program byte.
- `data_valid` in 1: byte offered.
- `data_ready` out 1: byte can be accepted (LOAD state and `ena`).
- `mem_we` out 1: program memory write strobe.
- `mem_addr` out 4: write address.
- `mem_wdata` out 8: write data.
- `cpu_ce` out 1: CPU clock enable, one cycle per instruction.
- `cpu_rst_n` out 1: CPU synchronous reset, active low.
- `loaded` out 1: a complete program is in memory.
- `state` out 2: 0 = IDLE, 1 = LOAD, 2 = RUN, 3 = STEP.

## Operation
- **Reset values:**
  - `state` = IDLE; `loaded`, `mem_we`, `cpu_ce`, `data_ready` and `cpu_rst_n` all 0.
  - `mem_addr` = 0, `mem_wdata` = 0; prescaler count = 0, `div_q` = 0.
- **IDLE:**
  - LOAD → LOAD: clears `loaded`, drives `cpu_rst_n` = 0, zeroes the address counter.
  - RUN → RUN, only if `loaded`: latches `div_q` = `div`, zeroes the prescaler, sets `cpu_rst_n` = 1.
  - STEP → STEP, only if `loaded`: sets `cpu_rst_n` = 1.
  - RUN or STEP while `!loaded`: ignored. HALT: no-op.
- **LOAD:**
  - `data_ready` = 1. On each handshake (`data_valid` & `data_ready`), the next cycle carries `mem_we` = 1, `mem_addr` = counter, `mem_wdata` = `data_in`; the counter then increments.
  - The handshake that writes address 15 sets `loaded` = 1 and returns to IDLE.
  - HALT aborts the load to IDLE: `loaded` stays 0 and `cpu_rst_n` stays 0.
  - LOAD, RUN and STEP are ignored while in LOAD.
- **RUN:**
  - The prescaler counts 0..`div_q`. `cpu_ce` = 1 in every cycle where count == `div_q`; the count then wraps to 0.
  - HALT → IDLE. LOAD → LOAD, which reasserts CPU reset. STEP and RUN are ignored.
- **STEP:** exactly one cycle with `cpu_ce` = 1, then IDLE. Commands arriving during STEP are ignored.
- **Simultaneous events:**
  - HALT in the same cycle as `data_valid` in LOAD: HALT wins and the byte is not written.
  - A command in the same cycle as the RUN strobe: the strobe still issues.
- **`ena` = 0:** `state`, counters and `loaded` hold. `data_ready`, `mem_we` and `cpu_ce` are forced to 0. `cmd_valid` is ignored.
- `cpu_rst_n` stays 1 across IDLE/RUN/STEP after the first RUN or STEP. It returns to 0 only on LOAD entry or `rst_n`.

## Timing
- All outputs are registered.
- A command at edge n takes effect in the state at n+1.
- RUN accepted at n: `cpu_ce` at cycles n+1+`div_q`, n+2+2·`div_q`, and so on.
  - `div` = 0: `cpu_ce` in every RUN cycle.
  - `div` = 255: period of 256 cycles.
- STEP accepted at n: `cpu_ce` high only in cycle n+1.
- Byte handshake at n: `mem_we` in cycle n+1. Peak throughput is 1 byte/cycle, so 16 bytes take 16 cycles minimum.
- Asynchronous `rst_n` mid-LOAD or mid-RUN: all outputs return to their reset values immediately, `loaded` = 0, and no partial `mem_we` is left asserted.

## Structure
- Package `td4_ctrl_pkg`:
  - state enum: IDLE, LOAD, RUN, STEP.
  - command codes: CMD_LOAD, CMD_RUN, CMD_STEP, CMD_HALT.
  - `PROG_DEPTH` default and address width constant.
- Sub-module `td4_prescaler`: `div_q` latch, count register and strobe output, with `clr` and `en` inputs.
- The FSM, load counter and `loaded` flag live in `td4_run_ctrl`.

## Test plan
- Reset, then LOAD with 16 bytes 0x00..0x0F streamed back-to-back:
  - 16 `mem_we` pulses, addresses 0..15, data matching.
  - `loaded` = 1 and `state` = IDLE after the last byte.
  - `cpu_rst_n` = 0 throughout.
- RUN with `div` = 3 after a load: `cpu_rst_n` rises, and `cpu_ce` pulses at RUN+4, +8, +12. HALT stops the pulses next cycle; `cpu_rst_n` stays 1.
- STEP ×3 with gaps: exactly 3 single-cycle `cpu_ce` pulses. RUN/STEP with `loaded` = 0 after reset: `state` stays IDLE and `cpu_ce` never fires.
- LOAD aborted by HALT after 5 bytes, with HALT colliding with a 6th `data_valid`:
  - exactly 5 writes (addresses 0..4).
  - `loaded` = 0; a subsequent RUN is ignored.
- RUN with `div` = 0, deassert `ena` for 4 cycles, then reassert: `cpu_ce` every cycle except while `ena` = 0, and prescaler/state preserved.
- `rst_n` pulsed mid-RUN and mid-LOAD (after 7 bytes): all outputs at reset values in the same cycle, `loaded` = 0, and a fresh LOAD restarts at address 0.
